// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register field width,
// mult/div sequencer states and the register-dependency helper.
package mips_pkg;

    localparam int unsigned REG_W          = 5;
    localparam int unsigned MD_LATENCY_DEF = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // $zero is never a real producer, so a write to it can never create a hazard.
    function automatic logic reg_match(
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (dest != '0) && ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Mult/div occupancy sequencer: busy for MD_LATENCY cycles after a start,
// then a one-cycle done pulse.
module md_seq
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    cnt_n   = CNT_W'(MD_LATENCY - 1);
                    state_n = MD_BUSY;
                end
            end
            // A start seen here is dropped: the ID-stage interlock should make it impossible.
            MD_BUSY: begin
                busy = 1'b1;
                if (cnt == '0) state_n = MD_DONE;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            MD_DONE: begin
                done = 1'b1;
                if (start) begin
                    cnt_n   = CNT_W'(MD_LATENCY - 1);
                    state_n = MD_BUSY;
                end else begin
                    state_n = MD_IDLE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch/jr operand
// hazards and mult/div HI/LO interlock, plus a stalled-cycle counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             uses_rt_d,
    input  logic             branch_d,
    input  logic             branch_taken_d,
    input  logic             jump_d,
    input  logic             md_op_d,
    input  logic             hilo_rd_d,
    input  logic             regwrite_e,
    input  logic             memtoreg_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic             md_start_e,
    input  logic             regwrite_m,
    input  logic             memtoreg_m,
    input  logic [REG_W-1:0] writereg_m,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [31:0]      stall_cycles
);

    logic lw_stall, br_stall, jr_stall, md_stall, stall;

    md_seq #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk   (clk),
        .rst   (rst),
        .start (md_start_e),
        .busy  (md_busy),
        .done  (md_done)
    );

    always_comb begin
        lw_stall = memtoreg_e & regwrite_e & reg_match(writereg_e, rs_d, rt_d, uses_rt_d);
        br_stall = branch_d &
                   ((regwrite_e & reg_match(writereg_e, rs_d, rt_d, uses_rt_d)) |
                    (memtoreg_m & regwrite_m & reg_match(writereg_m, rs_d, rt_d, uses_rt_d)));
        // jr only reads rs, so rt is masked out of the comparison.
        jr_stall = ~branch_d & jump_d &
                   ((regwrite_e & reg_match(writereg_e, rs_d, rt_d, 1'b0)) |
                    (memtoreg_m & regwrite_m & reg_match(writereg_m, rs_d, rt_d, 1'b0)));
        md_stall = (hilo_rd_d | md_op_d) & (md_busy | md_start_e);
        stall    = lw_stall | br_stall | jr_stall | md_stall;

        // Reset forces a frozen front end with a bubble into EX.
        pc_wr       = rst & ~stall;
        if_id_wr    = rst & ~stall;
        id_ex_flush = ~rst | stall;
        if_id_flush = rst & ((branch_d & branch_taken_d) | jump_d) & ~stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       stall_cycles <= '0;
        else if (stall) stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. Detects load-use and branch-in-ID data hazards and sequences the multi-cycle mult/div unit with a busy counter. Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble insertion. Sits beside the pipeline registers; all hazard outputs are combinational from stage fields plus the internal mult/div state.

Parameters:
MD_LATENCY, 32, mult/div busy cycles after start; legal range 2..255
CNT_W, 8, width of the mult/div down-counter; must satisfy 2^CNT_W > MD_LATENCY

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset; 0 = reset
rs_d  in  5  ID-stage rs field
rt_d  in  5  ID-stage rt field
uses_rt_d  in  1  ID instruction reads rt as a source
branch_d  in  1  ID instruction is a conditional branch resolved in ID
branch_taken_d  in  1  ID branch compare result (valid when branch_d=1)
jump_d  in  1  ID instruction is j/jal/jr
md_op_d  in  1  ID instruction is mult/multu/div/divu
hilo_rd_d  in  1  ID instruction is mfhi/mflo
regwrite_e  in  1  EX instruction writes a register
memtoreg_e  in  1  EX instruction is a load
writereg_e  in  5  EX destination register
md_start_e  in  1  EX instruction launches mult/div this cycle
regwrite_m  in  1  MEM instruction writes a register
memtoreg_m  in  1  MEM instruction is a load
writereg_m  in  5  MEM destination register
pc_wr  out  1  PC write enable
if_id_wr  out  1  IF/ID write enable (0 = hold)
if_id_flush  out  1  clear IF/ID (squash fetched instruction)
id_ex_flush  out  1  clear ID/EX (insert bubble)
md_busy  out  1  mult/div unit occupied
md_done  out  1  one-cycle pulse, result in HI/LO ready
stall_cycles  out  32  count of cycles with stall=1

Behaviour:
- Matches ignore register 0: a match requires dest!=0 and dest==rs_d, or dest==rt_d with uses_rt_d=1.
- lw_stall = memtoreg_e & regwrite_e & match(writereg_e).
- br_stall = branch_d & ((regwrite_e & match(writereg_e)) | (memtoreg_m & regwrite_m & match(writereg_m))). jr uses the same rule with jump_d when rs_d is the source; jr is flagged by branch_d=0, jump_d=1, and only rs is compared.
- md_stall = (hilo_rd_d | md_op_d) & (md_busy | md_start_e).
- stall = lw_stall | br_stall | md_stall.
- pc_wr = if_id_wr = ~stall; id_ex_flush = stall.
- if_id_flush = ((branch_d & branch_taken_d) | jump_d) & ~stall. Stall has priority: no flush while operands are unresolved.
- Mult/div FSM states:
  - IDLE: on md_start_e, load cnt=MD_LATENCY-1 and go to BUSY.
  - BUSY: md_busy=1; cnt decrements each cycle; at cnt==0 go to DONE.
  - DONE: md_done=1 for one cycle, md_busy=0; return to IDLE, or re-enter BUSY if md_start_e is set that cycle.
- md_busy is therefore high for exactly MD_LATENCY cycles starting the cycle after md_start_e.
- md_start_e while BUSY is illegal because it is prevented by md_stall. It is ignored and the counter is not reloaded; the bench flags it as an assertion.
- stall_cycles increments on every clk edge where stall=1 and wraps modulo 2^32.
- While rst=0, asynchronously: FSM=IDLE, cnt=0, md_busy=0, md_done=0, stall_cycles=0, pc_wr=0, if_id_wr=0, if_id_flush=0, id_ex_flush=1. Reset mid-mult/div aborts it with no md_done pulse.
- First cycle after reset release: normal combinational behaviour.

Decomposition:
- Shared package mips_pkg: REG_W=5, the FSM state encoding (MD_IDLE, MD_BUSY, MD_DONE), and the MD_LATENCY default.
- One sub-module, md_seq: the FSM plus the down-counter, producing md_busy and md_done.
- Hazard equations and the perf counter stay in the top level.

Test Plan:
- Load-use: memtoreg_e=1, regwrite_e=1, writereg_e=8, rs_d=8 -> pc_wr=0, if_id_wr=0, id_ex_flush=1 for 1 cycle; stall_cycles goes 0->1. Repeat with writereg_e=0 -> no stall.
- Branch hazard: branch_d=1, rs_d=9, regwrite_e=1, writereg_e=9, branch_taken_d=1 -> stall=1 and if_id_flush=0. Next cycle (no match), taken -> if_id_flush=1, pc_wr=1.
- Branch behind load in MEM: branch_d=1, rt_d=4, uses_rt_d=1, memtoreg_m=1, regwrite_m=1, writereg_m=4 -> one stall cycle. Jump jump_d=1 with no hazard -> if_id_flush=1.
- Mult/div (MD_LATENCY=4): md_start_e pulse at cycle t -> md_busy=1 for cycles t+1..t+4, md_done=1 at t+5. An mflo held in ID from t -> stalled t..t+4, released at t+5; stall_cycles +=5.
- Reset mid-operation: assert rst=0 at t+2 of a mult/div -> md_busy=0 immediately, no md_done, stall_cycles=0, id_ex_flush=1. Release -> IDLE behaviour.
- Back-to-back: md_start_e in the DONE cycle -> re-enters BUSY with md_busy continuous apart from the 1-cycle DONE gap, and a second md_done after another MD_LATENCY cycles.
